data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: WAIT_CYCLES, 1, extra stall cycles inserted before each response (legal 0..15).
REQ-002 Parameter: DEPTH, 1024, number of 32-bit words held.
REQ-003 Port: MAX10_CLK1_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: rden  input  1  read request from the CPU data path.
REQ-006 Port: wren  input  1  write request from the CPU data path.
REQ-007 Port: address  input  10  word address of the request.
REQ-008 Port: data  input  32  write data.
REQ-009 Port: q  output  32  read data, valid when ready is high and the completed operation is a read.
REQ-010 Port: ready  output  1  one-cycle completion pulse per accepted request.
REQ-011 Port: busy  output  1  high while a request is in flight; new requests are ignored.
REQ-012 Port: err  output  1  one-cycle pulse when rden and wren are accepted together.

Function
REQ-013 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-014 IDLE: rden or wren high at edge N -> accept; latch address, data, op; go WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 WAIT: count down WAIT_CYCLES cycles from the accept edge, then go RESP.
REQ-016 RESP: write commits data to the latched address; read loads q from the latched address; ready high for exactly one cycle; return to IDLE.
REQ-017 Latency: ready asserted in cycle N+1+WAIT_CYCLES after the accept edge N.
REQ-018 busy high from cycle N+1 through the ready cycle inclusive; low in IDLE.
REQ-019 Requests presented while busy are dropped, not queued; the CPU holds its request until ready.
REQ-020 rden and wren both high at accept: treated as write, no read data returned, err pulses coincident with ready.
REQ-021 q holds the last read value until the next read completes; writes never change q.
REQ-022 A read of an address written by the immediately preceding request returns the new data.
REQ-023 Address is a word index; no wrap or truncation required at DEPTH=1024; for smaller DEPTH, upper address bits are ignored (modulo DEPTH).
REQ-024 Next accept earliest at the edge after ready (back-to-back throughput one request per WAIT_CYCLES+2 cycles).

Reset
REQ-025 reset forces state IDLE, q=0, ready=0, busy=0, err=0, wait counter=0.
REQ-026 reset mid-request aborts it: no write committed, no ready pulse.
REQ-027 Storage array contents are not cleared by reset.

Configuration
REQ-028 With DATA_MEM_RESPONDER_MMIO_EN defined, address 0x3FF maps to a free-running 32-bit cycle counter (0 on reset, +1 per clock, wraps 0xFFFFFFFF->0); reads return the counter value at the RESP cycle; writes are ignored but still complete with ready.
REQ-029 Without DATA_MEM_RESPONDER_MMIO_EN, 0x3FF is an ordinary storage word and no counter exists.

Structure
REQ-030 Shared package mem_resp_pkg holds the FSM state enum, ADDR_W=10, DATA_W=32, and MMIO_ADDR=10'h3FF.
REQ-031 Storage lives in one sub-module sram_1024x32 (single-port, synchronous write, registered read); FSM, wait counter and MMIO decode stay in the top.

Verification
REQ-032 WAIT_CYCLES=1: write 0xDEADBEEF to 0x005, then read 0x005 -> each ready 2 cycles after accept; q=0xDEADBEEF.
REQ-033 WAIT_CYCLES=0: read 0x010 after reset with prior write 0x12345678 -> ready next cycle, busy high only that cycle, q=0x12345678.
REQ-034 rden=wren=1, address 0x020, data 0xA5A5A5A5 -> err and ready pulse together; later read 0x020 returns 0xA5A5A5A5; q unchanged by the error request.
REQ-035 WAIT_CYCLES=3: second request raised while busy -> ignored; only one ready; held request accepted the edge after ready.
REQ-036 reset asserted during WAIT of a write of 0x11111111 to 0x030 (old 0x22222222) -> no ready; read 0x030 returns 0x22222222; q=0 right after reset.
REQ-037 MMIO_EN defined: two reads of 0x3FF accepted 10 cycles apart -> values differ by exactly 10; write to 0x3FF does not change counter progression.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the CPU data-memory responder and its storage.
package mem_resp_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] MMIO_ADDR = 10'h3FF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // One accepted request, captured at the accept edge.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              is_write;
        logic              both;
    } req_t;

    // Word index into a store of 'depth' words; upper address bits fold away.
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a, input int depth);
        return ADDR_W'(32'(a) % 32'(depth));
    endfunction

endpackage

// File: rtl/sram_1024x32.sv
// Single-port word store: synchronous write, registered read (read-before-write).
module sram_1024x32
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose -- contents survive reset and
    // a reset port would stop the tools from mapping it onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: IDLE/WAIT/RESP handshake with programmable stall.
// Optional DATA_MEM_RESPONDER_MMIO_EN maps 0x3FF to a free-running cycle counter.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH       = 1024
) (
    input  logic              MAX10_CLK1_50,
    input  logic              reset,
    input  logic              rden,
    input  logic              wren,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] q,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int         MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state;
    req_t              req;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] q_hold;
    logic              accept;
    logic              is_mmio;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr_full;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] sram_rdata;
    logic [DATA_W-1:0] rd_data;

    assign accept = (state == S_IDLE) && (rden || wren);

    // In IDLE the store is addressed straight from the port so that read data
    // is already registered when RESP follows the accept edge with no stall.
    assign mem_addr_full = (state == S_IDLE) ? address : req.addr;
    assign mem_addr      = MEM_AW'(wrap_addr(mem_addr_full, DEPTH));
    assign mem_we        = (state == S_RESP) && req.is_write && !is_mmio;

    sram_1024x32 #(
        .DEPTH (DEPTH),
        .AW    (MEM_AW)
    ) u_sram (
        .clk   (MAX10_CLK1_50),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (req.data),
        .rdata (sram_rdata)
    );

`ifdef DATA_MEM_RESPONDER_MMIO_EN
    logic [DATA_W-1:0] cycle_cnt;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    assign is_mmio = (req.addr == MMIO_ADDR);
    assign rd_data = is_mmio ? cycle_cnt : sram_rdata;
`else
    assign is_mmio = 1'b0;
    assign rd_data = sram_rdata;
`endif

    // NOTE: the request capture register carries no reset; it is only
    // consulted outside IDLE, and every exit from IDLE reloads it.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (accept) begin
            req <= '{addr: address, data: data, is_write: wren, both: rden && wren};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples the pre-edge values regardless of statement order.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            q_hold   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rden || wren) begin
                        state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    if (!req.is_write) begin
                        q_hold <= rd_data;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read data is visible during the ready cycle itself, then held.
    assign q     = (state == S_RESP && !req.is_write) ? rd_data : q_hold;
    assign ready = (state == S_RESP);
    assign busy  = (state != S_IDLE);
    assign err   = (state == S_RESP) && req.both;

endmodule
